// File: rtl/reset_sequencer.sv
// Staged reset release driven by PLL lock: synchronise lock, qualify it for
// LOCK_CYCLES, release sys reset, then CPU reset STAGE_CYCLES later.
module reset_sequencer #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned LOCK_CYCLES  = 63000,
    parameter int unsigned STAGE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic locked,
    input  logic soft_reset,
    output logic sys_reset_n,
    output logic cpu_reset_n,
    output logic ready,
    output logic lock_lost
);

    localparam int unsigned MAX_CYCLES = (LOCK_CYCLES > STAGE_CYCLES) ? LOCK_CYCLES : STAGE_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        SETTLE    = 3'd1,
        REL_SYS   = 3'd2,
        RUN       = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next, cnt_inc;
    logic [SYNC_STAGES-1:0] sync;
    logic               lock_s;
    logic               lock_lost_next;
    logic               sys_next, cpu_next;

    assign lock_s  = sync[SYNC_STAGES-1];
    // Saturating increment so the counter can never wrap back to a match value.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);

    // Lock synchroniser
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], locked};
        end
    end

    // State, counter and registered output decodes of the next state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT_LOCK;
            cnt         <= '0;
            sys_reset_n <= 1'b0;
            cpu_reset_n <= 1'b0;
            ready       <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            sys_reset_n <= sys_next;
            cpu_reset_n <= cpu_next;
            ready       <= cpu_next;
            lock_lost   <= lock_lost_next;
        end
    end

    // Next-state logic; lock loss takes priority over soft reset
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        lock_lost_next = lock_lost;

        case (state)
            WAIT_LOCK: begin
                cnt_next = '0;
                if (lock_s) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_next = REL_SYS;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            REL_SYS: begin
                if (!lock_s) begin
                    state_next     = WAIT_LOCK;
                    cnt_next       = '0;
                    lock_lost_next = 1'b1;
                end else if (soft_reset) begin
                    state_next     = HOLD;
                    cnt_next       = '0;
                    lock_lost_next = 1'b0;
                end else if (cnt == STAGE_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            RUN: begin
                cnt_next = '0;
                if (!lock_s) begin
                    state_next     = WAIT_LOCK;
                    lock_lost_next = 1'b1;
                end else if (soft_reset) begin
                    state_next     = HOLD;
                    lock_lost_next = 1'b0;
                end
            end
            HOLD: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STAGE_LAST) begin
                    state_next = REL_SYS;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase

        sys_next = (state_next == REL_SYS) || (state_next == RUN);
        cpu_next = (state_next == RUN);
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with SYNC_STAGES=2, LOCK_CYCLES=8,
// STAGE_CYCLES=4; observed vector is {sys_reset_n, cpu_reset_n, ready, lock_lost}.
module tb_reset_sequencer;

    logic clock;
    logic reset_n;
    logic locked;
    logic soft_reset;
    logic sys_reset_n;
    logic cpu_reset_n;
    logic ready;
    logic lock_lost;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(
        .SYNC_STAGES (2),
        .LOCK_CYCLES (8),
        .STAGE_CYCLES(4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .locked     (locked),
        .soft_reset (soft_reset),
        .sys_reset_n(sys_reset_n),
        .cpu_reset_n(cpu_reset_n),
        .ready      (ready),
        .lock_lost  (lock_lost)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] got;
        reset_n    = 1'b0;
        locked     = 1'b0;
        soft_reset = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        got = {sys_reset_n, cpu_reset_n, ready, lock_lost};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got %b expected %b", got, 4'b0000);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_power_up();
        logic [3:0] got, exp;
        locked = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            got = {sys_reset_n, cpu_reset_n, ready, lock_lost};
            exp = {e >= 11, e >= 15, e >= 15, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL power_up edge %0d got %b expected %b", e, got, exp);
            end
        end
    endtask

    task automatic test_lock_bounce();
        logic [3:0] got, exp;
        reset_n = 1'b0;
        locked  = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        // high 5 edges, low 2, then high for good: final rise is edge 8
        for (int e = 1; e <= 22; e++) begin
            locked = (e < 6) || (e > 7);
            tick();
            got = {sys_reset_n, cpu_reset_n, ready, lock_lost};
            exp = {e >= 18, e >= 22, e >= 22, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL lock_bounce edge %0d got %b expected %b", e, got, exp);
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [3:0] got, exp;
        locked = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            tick();
            got = {sys_reset_n, cpu_reset_n, ready, lock_lost};
            exp = (e < 3) ? 4'b1110 : 4'b0001;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL lock_loss edge %0d got %b expected %b", e, got, exp);
            end
        end
        locked = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            got = {sys_reset_n, cpu_reset_n, ready, lock_lost};
            exp = {e >= 11, e >= 15, e >= 15, 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL relock edge %0d got %b expected %b", e, got, exp);
            end
        end
    endtask

    task automatic test_soft_reset();
        logic [3:0] got, exp;
        soft_reset = 1'b1;
        tick();
        soft_reset = 1'b0;
        got = {sys_reset_n, cpu_reset_n, ready, lock_lost};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL soft_reset edge 1 got %b expected %b", got, 4'b0000);
        end
        for (int e = 2; e <= 10; e++) begin
            tick();
            got = {sys_reset_n, cpu_reset_n, ready, lock_lost};
            exp = {e >= 5, e >= 9, e >= 9, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL soft_reset edge %0d got %b expected %b", e, got, exp);
            end
        end
    endtask

    task automatic test_soft_lock_coincident();
        logic [3:0] got, exp;
        locked = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            soft_reset = (e == 3);
            tick();
            got = {sys_reset_n, cpu_reset_n, ready, lock_lost};
            exp = (e < 3) ? 4'b1110 : 4'b0001;
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL soft_vs_lock edge %0d got %b expected %b", e, got, exp);
            end
        end
        soft_reset = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [3:0] got, exp;
        locked = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            got = {sys_reset_n, cpu_reset_n, ready, lock_lost};
            exp = {e >= 11, 1'b0, 1'b0, 1'b1};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL rel_sys_entry edge %0d got %b expected %b", e, got, exp);
            end
        end
        // pulse reset_n low between edges while in REL_SYS
        #2;
        reset_n = 1'b0;
        #1;
        got = {sys_reset_n, cpu_reset_n, ready, lock_lost};
        checks++;
        if (got !== 4'b0000) begin
            errors++;
            $display("FAIL async_reset got %b expected %b", got, 4'b0000);
        end
        #1;
        reset_n = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            tick();
            got = {sys_reset_n, cpu_reset_n, ready, lock_lost};
            exp = {e >= 11, e >= 15, e >= 15, 1'b0};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL restart edge %0d got %b expected %b", e, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_bounce();
        test_lock_loss();
        test_soft_reset();
        test_soft_lock_coincident();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
